// File: rtl/alu_seq.sv
// Multi-cycle ALU for the execute stage: registered single-cycle ops, a bit-serial
// shift-by-N and a shift-add multiply behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             carry_in,
    input  logic             direction,
    input  logic             use_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] mul_hi,
    output logic             carry_out,
    output logic [1:0]       compareFlag
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIN} state_e;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_PASSB = 4'd5;
    localparam logic [3:0] OP_PASSA = 4'd6;
    localparam logic [3:0] OP_CMP   = 4'd7;
    localparam logic [3:0] OP_SHIFT = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
    localparam logic [SHW-1:0] CNT_MUL = SHW'(WIDTH - 1);

    state_e             stateQ, stateD;
    logic [3:0]         opQ, opD;
    logic [WIDTH-1:0]   aQ, aD, bQ, bD;
    logic               cinQ, cinD, dirQ, dirD, fillQ, fillD;
    logic [SHW-1:0]     cntQ, cntD;
    logic [WIDTH-1:0]   workQ, workD;
    logic [2*WIDTH-1:0] prodQ, prodD;
    logic [WIDTH-1:0]   dataQ, dataD, hiQ, hiD;
    logic               coutQ, coutD;
    logic [1:0]         cmpQ, cmpD;

    logic [WIDTH-1:0]   shNext;
    logic               shOut;
    logic [WIDTH:0]     addHi;
    logic [2*WIDTH-1:0] prodNext;
    logic [WIDTH:0]     sum;

    // One step of the serial shifter; a zero shift amount leaves A untouched.
    always_comb begin
        shNext = workQ;
        shOut  = 1'b0;
        if (bQ[SHW-1:0] != '0) begin
            if (dirQ) begin
                {shOut, shNext} = {workQ, fillQ};
            end else begin
                {shNext, shOut} = {fillQ, workQ};
            end
        end
    end

    // Shift-add multiply step: low half holds the remaining multiplier bits.
    always_comb begin
        addHi    = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + (prodQ[0] ? {1'b0, aQ} : '0);
        prodNext = {addHi, prodQ[WIDTH-1:1]};
        sum      = {1'b0, aQ} + {1'b0, (opQ == OP_SUB) ? ~bQ : bQ} + (WIDTH+1)'(cinQ);
    end

    always_comb begin
        stateD = stateQ;
        opD    = opQ;
        aD     = aQ;
        bD     = bQ;
        cinD   = cinQ;
        dirD   = dirQ;
        fillD  = fillQ;
        cntD   = cntQ;
        workD  = workQ;
        prodD  = prodQ;
        dataD  = dataQ;
        hiD    = hiQ;
        coutD  = coutQ;
        cmpD   = cmpQ;

        case (stateQ)
            S_IDLE: begin
                if (start) begin
                    stateD = S_EXEC;
                    opD    = op;
                    aD     = inA;
                    bD     = inB;
                    cinD   = carry_in;
                    dirD   = direction;
                    fillD  = use_carry & carry_in;
                    workD  = inA;
                    prodD  = {{WIDTH{1'b0}}, inB};
                    if (op == OP_SHIFT) begin
                        cntD = (inB[SHW-1:0] == '0) ? '0 : inB[SHW-1:0] - CNT_ONE;
                    end else if (op == OP_MUL) begin
                        cntD = CNT_MUL;
                    end else begin
                        cntD = '0;
                    end
                end
            end
            S_EXEC: begin
                workD = shNext;
                prodD = prodNext;
                cntD  = cntQ - CNT_ONE;
                if (cntQ == '0) begin
                    stateD = S_FIN;
                    dataD  = '1;
                    hiD    = '0;
                    coutD  = 1'b0;
                    cmpD   = 2'b11;
                    case (opQ)
                        OP_AND:   dataD = aQ & bQ;
                        OP_OR:    dataD = aQ | bQ;
                        OP_ADD:   {coutD, dataD} = sum;
                        OP_SUB:   {coutD, dataD} = sum;
                        OP_PASSB: dataD = bQ;
                        OP_PASSA: dataD = aQ;
                        OP_CMP:   cmpD = {aQ == bQ, aQ > bQ};
                        OP_SHIFT: begin
                            dataD = shNext;
                            coutD = shOut;
                        end
                        OP_MUL:   {hiD, dataD} = prodNext;
                        default:  dataD = '1;
                    endcase
                end
            end
            S_FIN: begin
                stateD = S_IDLE;
            end
            default: begin
                stateD = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= S_IDLE;
            opQ    <= '0;
            aQ     <= '0;
            bQ     <= '0;
            cinQ   <= 1'b0;
            dirQ   <= 1'b0;
            fillQ  <= 1'b0;
            cntQ   <= '0;
            workQ  <= '0;
            prodQ  <= '0;
            dataQ  <= '0;
            hiQ    <= '0;
            coutQ  <= 1'b0;
            cmpQ   <= 2'b11;
        end else begin
            stateQ <= stateD;
            opQ    <= opD;
            aQ     <= aD;
            bQ     <= bD;
            cinQ   <= cinD;
            dirQ   <= dirD;
            fillQ  <= fillD;
            cntQ   <= cntD;
            workQ  <= workD;
            prodQ  <= prodD;
            dataQ  <= dataD;
            hiQ    <= hiD;
            coutQ  <= coutD;
            cmpQ   <= cmpD;
        end
    end

    assign busy        = (stateQ == S_EXEC);
    assign done        = (stateQ == S_FIN);
    assign data_out    = dataQ;
    assign mul_hi      = hiQ;
    assign carry_out   = coutQ;
    assign compareFlag = cmpQ;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors on an 8-bit instance plus
// one 16-bit ADD, with latency measured from the cycle start is driven.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset, start, start16;
    logic [3:0] op;
    logic [7:0] inA, inB;
    logic [15:0] inA16, inB16;
    logic       carry_in, direction, use_carry;

    logic       busy, done, carry_out;
    logic [7:0] data_out, mul_hi;
    logic [1:0] compareFlag;
    logic        busy16, done16, carry_out16;
    logic [15:0] data_out16, mul_hi16;
    logic [1:0]  compareFlag16;

    int errors = 0;
    int checks = 0;
    int lat;
    logic busyOk, sawDone;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
        .carry_in(carry_in), .direction(direction), .use_carry(use_carry),
        .busy(busy), .done(done), .data_out(data_out), .mul_hi(mul_hi),
        .carry_out(carry_out), .compareFlag(compareFlag)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .inA(inA16), .inB(inB16),
        .carry_in(carry_in), .direction(direction), .use_carry(use_carry),
        .busy(busy16), .done(done16), .data_out(data_out16), .mul_hi(mul_hi16),
        .carry_out(carry_out16), .compareFlag(compareFlag16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expected);
        end
    endtask

    // Launches one op, scrambles the inputs after the start edge, and returns the
    // cycle in which done rose (cycle 1 is the first cycle after start), then
    // steps into IDLE so the next op can start.
    task automatic applyStimulus(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic dir, input logic uc, output int latency);
        op = o; inA = a; inB = b; carry_in = cin; direction = dir; use_carry = uc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd2; inA = ~a; inB = ~b; carry_in = ~cin; direction = ~dir; use_carry = ~uc;
        latency = 1;
        while (done !== 1'b1 && latency < 40) begin
            @(posedge clk); #1;
            latency++;
        end
        if (done !== 1'b1) latency = 99;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start16 = 1'b0; op = '0; inA = '0; inB = '0;
        inA16 = '0; inB16 = '0; carry_in = 1'b0; direction = 1'b0; use_carry = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_data", data_out, 8'h00);
        checkOutput("rst_cmp", compareFlag, 2'b11);

        applyStimulus(4'd2, 8'hF0, 8'h20, 1'b1, 1'b0, 1'b0, lat);
        checkOutput("add_lat", lat, 2);
        checkOutput("add_data", data_out, 8'h11);
        checkOutput("add_cout", carry_out, 1);
        checkOutput("done_width", done, 0);
        checkOutput("add_hold", data_out, 8'h11);

        applyStimulus(4'd3, 8'h05, 8'h07, 1'b1, 1'b0, 1'b0, lat);
        checkOutput("sub_data", data_out, 8'hFE);
        checkOutput("sub_cout", carry_out, 0);

        // Reset in cycle 3 of a multiply: abandoned, no done afterwards.
        op = 4'd9; inA = 8'hFF; inB = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rmul_busy", busy, 0);
        checkOutput("rmul_done", done, 0);
        checkOutput("rmul_data", data_out, 8'h00);
        checkOutput("rmul_hi", mul_hi, 8'h00);
        checkOutput("rmul_cmp", compareFlag, 2'b11);
        sawDone = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0) sawDone = 1'b1;
        end
        checkOutput("rmul_nodone", sawDone, 0);

        applyStimulus(4'd7, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("cmp_gt", compareFlag, 2'b01);
        checkOutput("cmp_data", data_out, 8'hFF);
        applyStimulus(4'd7, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("cmp_eq", compareFlag, 2'b10);
        applyStimulus(4'd7, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("cmp_lt", compareFlag, 2'b00);
        applyStimulus(4'd0, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("and_cmp", compareFlag, 2'b11);
        checkOutput("and_data", data_out, 8'h30);

        applyStimulus(4'd8, 8'h81, 8'h03, 1'b1, 1'b1, 1'b1, lat);
        checkOutput("shl_lat", lat, 4);
        checkOutput("shl_data", data_out, 8'h0F);
        checkOutput("shl_cout", carry_out, 0);
        applyStimulus(4'd8, 8'h81, 8'h01, 1'b1, 1'b0, 1'b0, lat);
        checkOutput("shr_lat", lat, 2);
        checkOutput("shr_data", data_out, 8'h40);
        checkOutput("shr_cout", carry_out, 1);
        applyStimulus(4'd8, 8'h81, 8'h08, 1'b1, 1'b1, 1'b1, lat);
        checkOutput("sh0_lat", lat, 2);
        checkOutput("sh0_data", data_out, 8'h81);
        checkOutput("sh0_cout", carry_out, 0);

        // Multiply with a stray start in cycle 4 that must be ignored.
        op = 4'd9; inA = 8'hFF; inB = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0; inA = 8'h00; inB = 8'h00;
        lat = 1; busyOk = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            start = (lat == 4);
            if (lat == 4) begin op = 4'd2; inA = 8'h01; inB = 8'h01; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) lat = 99;
        checkOutput("mul_lat", lat, 9);
        checkOutput("mul_busy", busyOk, 1);
        checkOutput("mul_lo", data_out, 8'h01);
        checkOutput("mul_hi", mul_hi, 8'hFE);
        checkOutput("mul_cout", carry_out, 0);
        @(posedge clk); #1;
        checkOutput("mul_noqueue", busy, 0);

        applyStimulus(4'd5, 8'h11, 8'h5A, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("passb_data", data_out, 8'h5A);
        checkOutput("passb_hi", mul_hi, 8'h00);
        applyStimulus(4'd1, 8'hA0, 8'h05, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("or_data", data_out, 8'hA5);
        applyStimulus(4'd6, 8'h3E, 8'hC1, 1'b0, 1'b0, 1'b0, lat);
        checkOutput("passa_data", data_out, 8'h3E);

        applyStimulus(4'd8, 8'h81, 8'h01, 1'b0, 1'b0, 1'b0, lat);
        applyStimulus(4'd12, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, lat);
        checkOutput("ill_lat", lat, 2);
        checkOutput("ill_data", data_out, 8'hFF);
        checkOutput("ill_cout", carry_out, 0);

        op = 4'd2; inA16 = 16'hFFFF; inB16 = 16'h0001; carry_in = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; inA16 = 16'h0000; inB16 = 16'h0000; op = 4'd0;
        lat = 1;
        while (done16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done16 !== 1'b1) lat = 99;
        checkOutput("add16_lat", lat, 2);
        checkOutput("add16_data", data_out16, 16'h0000);
        checkOutput("add16_cout", carry_out16, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Single-cycle logic/arithmetic ops have registered results. New ops: shift-by-N, which runs one bit per cycle, and an unsigned shift-add multiply.
- start/busy/done handshake between the controller and this block.
- Sits in the execute stage. The controller stalls PC advance while busy=1.

Parameters:
WIDTH, 8, datapath width in bits (>=4)
SHW, $clog2(WIDTH), width of the shift-amount field taken from inB[SHW-1:0]

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  launch op; sampled only in IDLE
op  in  4  opcode, latched at start
inA  in  WIDTH  operand A, latched at start
inB  in  WIDTH  operand B, latched at start
carry_in  in  1  carry for ADD/SUB; fill bit for SHIFT when use_carry=1
direction  in  1  SHIFT direction: 1=left, 0=right
use_carry  in  1  SHIFT fill select: 1=carry_in, 0=zero
busy  out  1  high while op in progress, including the start cycle's successor cycles
done  out  1  one-cycle pulse when results become valid
data_out  out  WIDTH  result (MUL: low half)
mul_hi  out  WIDTH  MUL high half; 0 for other ops
carry_out  out  1  ADD/SUB carry, SHIFT last bit out, else 0
compareFlag  out  2  11 none, 10 A==B, 01 A>B, 00 A<B (unsigned)

Behaviour:
- Reset (synchronous, wins over everything, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, data_out=0, mul_hi=0, carry_out=0, compareFlag=11.
  - Any in-flight op is abandoned; no done pulse follows.
- States:
  - IDLE:
    - start=1 latches op, inA, inB, carry_in, direction and use_carry, then goes to EXEC.
    - busy rises the next cycle.
  - EXEC:
    - Single-cycle ops spend 1 cycle here.
    - SHIFT spends max(N,1) cycles, with N=inB[SHW-1:0].
    - MUL spends WIDTH cycles.
    - Go to FIN once the op's count expires.
  - FIN:
    - Outputs are updated; done=1 for exactly one cycle, busy=0.
    - Go to IDLE.
    - start sampled in FIN is ignored; start is accepted only in IDLE.
- Latency, start edge to done high:
  - Single-cycle ops: 2 cycles.
  - SHIFT: N+1 cycles for N>=1; 2 cycles for N=0.
  - MUL: WIDTH+1 cycles.
- start while busy=1 is ignored. It is not queued and latched operands are not disturbed.
- Output timing:
  - data_out, mul_hi, carry_out and compareFlag change only at the FIN entry edge, or on reset.
  - They hold until the next op completes.
  - compareFlag returns to 11 on completion of any non-CMP op.
- Opcodes (all arithmetic modulo 2^WIDTH, unsigned):
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 ADD: {carry_out,data_out} = A+B+carry_in.
  - 3 SUB: {carry_out,data_out} = A + ~B + carry_in. With carry_in=1 this is a true A-B, and carry_out=1 means no borrow.
  - 5 PASSB: B.
  - 6 PASSA: A.
  - 7 CMP:
    - data_out = all ones; compareFlag = {A==B, A>B}.
    - Because equality takes priority, A==B yields 10, never 11.
  - 8 SHIFT:
    - Each EXEC cycle shifts the working register by 1 toward direction.
    - The vacated bit is filled with (use_carry ? carry_in : 0); the same fill is used every step.
    - carry_out = the bit shifted out in the final step.
    - N=0: data_out=A, carry_out=0.
  - 9 MUL:
    - Shift-add over WIDTH cycles, one multiplier bit per cycle.
    - {mul_hi,data_out} = A*B (2*WIDTH bits, exact); carry_out=0.
  - 4, 10-15: illegal. data_out = all ones, carry_out=0, mul_hi=0. Single-cycle latency and done still pulse.
- Operands are latched: input changes after the start edge do not affect the result.

Test Plan:
- Reset mid-MUL: reset=1 on cycle 3 of MUL (A=0xFF, B=0xFF) -> next cycle busy=0, done never pulses, data_out=0x00, compareFlag=11.
- ADD/SUB, WIDTH=8:
  - ADD 0xF0+0x20, carry_in=1 -> data_out=0x11, carry_out=1, done 2 cycles after start.
  - SUB 0x05-0x07, carry_in=1 -> data_out=0xFE, carry_out=0.
- CMP, WIDTH=8:
  - A=0x80, B=0x7F -> compareFlag=01.
  - A=B=0x3C -> 10.
  - A=0x01, B=0x02 -> 00.
  - Subsequent AND op -> compareFlag=11.
- SHIFT, WIDTH=8:
  - Left, A=0x81, N=3, use_carry=1, carry_in=1 -> data_out=0x0F, carry_out=0, done 4 cycles after start.
  - Right, A=0x81, N=1, use_carry=0 -> data_out=0x40, carry_out=1.
  - N=0 -> data_out=0x81, latency 2.
- MUL, WIDTH=8: A=0xFF, B=0xFF -> mul_hi=0xFE, data_out=0x01, done at cycle 9. start pulsed at cycle 4 is ignored, and busy stays high throughout.
- Illegal op 12 -> data_out=0xFF, done at 2 cycles. Repeat ADD with WIDTH=16: 0xFFFF+0x0001 -> data_out=0x0000, carry_out=1.
